cc_adder_accumulator: RTL and testbench

- Sequential, parametrised successor to the team's two-operand combinational adder.
- Sums a stream of NUMBER_INPUTS operands, or fewer if terminated by a last flag, into one result.
- Optional signed arithmetic and saturation; overflow flag on every result.
- Sits in the neuron datapath between the weighted-input multipliers and the activation stage; valid/ready handshake on both sides.

---
 rtl/cc_adder_accumulator_if.sv | 62 ++++++
 rtl/cc_adder_accumulator.sv | 176 +++++++++++++++++
 tb/tb_cc_adder_accumulator.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cc_adder_accumulator_if.sv
//------------------------------------------------------------------------------
// cc_adder_accumulator_if
//
// Purpose:
//    Groups the operand-side and result-side valid/ready handshakes of the
//    adder/accumulator into a single bundle.
//
// Signals:
//    CC_ADDER_ACC_data_InBUS   [W]      operand
//    CC_ADDER_ACC_valid_In              operand valid
//    CC_ADDER_ACC_last_In               final operand of the current sum
//    CC_ADDER_ACC_ready_Out             accumulator can take an operand
//    CC_ADDER_ACC_sum_OutBUS   [W]      result (saturated or wrapped)
//    CC_ADDER_ACC_overflow_Out          true sum outside the W-bit range
//    CC_ADDER_ACC_count_OutBUS [CNT_W]  number of terms summed
//    CC_ADDER_ACC_valid_Out             result valid
//    CC_ADDER_ACC_ready_In              downstream accepts result
//
// Modports:
//    slave  - the accumulator itself
//    master - the surrounding datapath (producer of operands, consumer of results)
//------------------------------------------------------------------------------
interface cc_adder_accumulator_if #(
   parameter int NUMBER_DATAWIDTH = 8,
   parameter int NUMBER_INPUTS    = 4
);
   localparam int CNT_W = $clog2(NUMBER_INPUTS) + 1;

   logic [NUMBER_DATAWIDTH-1:0] CC_ADDER_ACC_data_InBUS;
   logic                        CC_ADDER_ACC_valid_In;
   logic                        CC_ADDER_ACC_last_In;
   logic                        CC_ADDER_ACC_ready_Out;
   logic [NUMBER_DATAWIDTH-1:0] CC_ADDER_ACC_sum_OutBUS;
   logic                        CC_ADDER_ACC_overflow_Out;
   logic [CNT_W-1:0]            CC_ADDER_ACC_count_OutBUS;
   logic                        CC_ADDER_ACC_valid_Out;
   logic                        CC_ADDER_ACC_ready_In;

   modport slave (
      input  CC_ADDER_ACC_data_InBUS,
      input  CC_ADDER_ACC_valid_In,
      input  CC_ADDER_ACC_last_In,
      output CC_ADDER_ACC_ready_Out,
      output CC_ADDER_ACC_sum_OutBUS,
      output CC_ADDER_ACC_overflow_Out,
      output CC_ADDER_ACC_count_OutBUS,
      output CC_ADDER_ACC_valid_Out,
      input  CC_ADDER_ACC_ready_In
   );

   modport master (
      output CC_ADDER_ACC_data_InBUS,
      output CC_ADDER_ACC_valid_In,
      output CC_ADDER_ACC_last_In,
      input  CC_ADDER_ACC_ready_Out,
      input  CC_ADDER_ACC_sum_OutBUS,
      input  CC_ADDER_ACC_overflow_Out,
      input  CC_ADDER_ACC_count_OutBUS,
      input  CC_ADDER_ACC_valid_Out,
      output CC_ADDER_ACC_ready_In
   );
endinterface

// File: rtl/cc_adder_accumulator.sv
//------------------------------------------------------------------------------
// cc_adder_accumulator
//
// Purpose:
//    Sums a stream of up to NUMBER_INPUTS operands (fewer when a term is
//    flagged last) into one NUMBER_DATAWIDTH-bit result. Arithmetic may be
//    unsigned or two's-complement, and the result either clamps or wraps.
//    An overflow flag accompanies every result.
//
// Ports:
//    CC_ADDER_ACC_CLOCK_50     in   system clock, rising edge
//    CC_ADDER_ACC_RESET_InLow  in   synchronous active-low reset
//    CC_ADDER_ACC_bus          slave modport of cc_adder_accumulator_if
//                                   (operand handshake in, result handshake out)
//
// Operation:
//    IDLE  -> first accepted operand loads the accumulator
//    ACCUM -> further operands are added; valid_In low stalls indefinitely
//    DONE  -> result held until the downstream handshake, then back to IDLE
//------------------------------------------------------------------------------
module cc_adder_accumulator #(
   parameter int NUMBER_DATAWIDTH = 8,
   parameter int NUMBER_INPUTS    = 4,
   parameter int SIGNED_MODE      = 0,
   parameter int SATURATE_MODE    = 1
) (
   input  logic                   CC_ADDER_ACC_CLOCK_50,
   input  logic                   CC_ADDER_ACC_RESET_InLow,
   cc_adder_accumulator_if.slave  CC_ADDER_ACC_bus
);

   localparam int W     = NUMBER_DATAWIDTH;
   localparam int CNT_W = $clog2(NUMBER_INPUTS) + 1;
   // Wide enough for NUMBER_INPUTS full-scale operands plus a sign bit,
   // so the running sum itself can never overflow.
   localparam int ACC_W = W + $clog2(NUMBER_INPUTS) + 1;

   // Representable result range, expressed at accumulator width.
   localparam logic [ACC_W-1:0] UMAX = {{(ACC_W-W){1'b0}}, {W{1'b1}}};
   localparam logic [ACC_W-1:0] SMAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SMIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [W-1:0]       sum_q;
   logic               ovf_q;
   logic [CNT_W-1:0]   count_q;
   logic               valid_q;
   logic               ready_q;

   logic [ACC_W-1:0]   data_ext;
   logic [ACC_W-1:0]   acc_d;
   logic [CNT_W-1:0]   cnt_d;
   logic [W-1:0]       sum_d;
   logic               ovf_d;
   logic               accept;
   logic               term_done;

   assign accept = CC_ADDER_ACC_bus.CC_ADDER_ACC_valid_In & ready_q;

   //---------------------------------------------------------------------------
   // Operand extension, next accumulator value and result formatting
   //---------------------------------------------------------------------------
   always_comb begin
      data_ext = '0;
      if (SIGNED_MODE != 0) begin
         data_ext = {{(ACC_W-W){CC_ADDER_ACC_bus.CC_ADDER_ACC_data_InBUS[W-1]}},
                     CC_ADDER_ACC_bus.CC_ADDER_ACC_data_InBUS};
      end else begin
         data_ext = {{(ACC_W-W){1'b0}}, CC_ADDER_ACC_bus.CC_ADDER_ACC_data_InBUS};
      end
   end

   always_comb begin
      acc_d = '0;
      cnt_d = '0;
      if (state_q == IDLE) begin
         acc_d = data_ext;
         cnt_d = CNT_W'(1);
      end else begin
         acc_d = acc_q + data_ext;
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign term_done = CC_ADDER_ACC_bus.CC_ADDER_ACC_last_In
                    | (cnt_d == CNT_W'(NUMBER_INPUTS));

   always_comb begin
      ovf_d = 1'b0;
      if (SIGNED_MODE != 0) begin
         ovf_d = ($signed(acc_d) > $signed(SMAX)) || ($signed(acc_d) < $signed(SMIN));
      end else begin
         ovf_d = (acc_d > UMAX);
      end
   end

   always_comb begin
      sum_d = acc_d[W-1:0];
      if ((SATURATE_MODE != 0) && ovf_d) begin
         if (SIGNED_MODE != 0) begin
            // The accumulator's sign bit tells which rail was crossed.
            sum_d = acc_d[ACC_W-1] ? SMIN[W-1:0] : SMAX[W-1:0];
         end else begin
            sum_d = UMAX[W-1:0];
         end
      end
   end

   //---------------------------------------------------------------------------
   // Control FSM with registered outputs
   //---------------------------------------------------------------------------
   always_ff @(posedge CC_ADDER_ACC_CLOCK_50) begin
      if (!CC_ADDER_ACC_RESET_InLow) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
         count_q <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_d;
                  if (term_done) begin
                     // Result registers load on the same edge as the final term.
                     state_q <= DONE;
                     sum_q   <= sum_d;
                     ovf_q   <= ovf_d;
                     count_q <= cnt_d;
                     valid_q <= 1'b1;
                     ready_q <= 1'b0;
                  end else begin
                     state_q <= ACCUM;
                  end
               end
            end
            DONE: begin
               if (CC_ADDER_ACC_bus.CC_ADDER_ACC_ready_In) begin
                  // sum/overflow/count deliberately keep their last values.
                  state_q <= IDLE;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               acc_q   <= '0;
               cnt_q   <= '0;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign CC_ADDER_ACC_bus.CC_ADDER_ACC_ready_Out    = ready_q;
   assign CC_ADDER_ACC_bus.CC_ADDER_ACC_sum_OutBUS   = sum_q;
   assign CC_ADDER_ACC_bus.CC_ADDER_ACC_overflow_Out = ovf_q;
   assign CC_ADDER_ACC_bus.CC_ADDER_ACC_count_OutBUS = count_q;
   assign CC_ADDER_ACC_bus.CC_ADDER_ACC_valid_Out    = valid_q;

endmodule

// File: tb/tb_cc_adder_accumulator.sv
//------------------------------------------------------------------------------
// tb_cc_adder_accumulator
//
// Three accumulators (W=8, N=4) share one operand stream:
//    dut 0: unsigned, saturating
//    dut 1: unsigned, wrapping
//    dut 2: signed,   saturating
// Each vector carries the expected result for all three.
//------------------------------------------------------------------------------
module tb_cc_adder_accumulator;

   localparam int W = 8;
   localparam int N = 4;
   localparam int CNT_W = $clog2(N) + 1;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  data;
   logic          valid;
   logic          last;
   logic          rdy_in;

   int ncmp = 0;
   int nerr = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cc_adder_accumulator_if #(.NUMBER_DATAWIDTH(W), .NUMBER_INPUTS(N)) bus0 ();
   cc_adder_accumulator_if #(.NUMBER_DATAWIDTH(W), .NUMBER_INPUTS(N)) bus1 ();
   cc_adder_accumulator_if #(.NUMBER_DATAWIDTH(W), .NUMBER_INPUTS(N)) bus2 ();

   assign bus0.CC_ADDER_ACC_data_InBUS = data;
   assign bus0.CC_ADDER_ACC_valid_In   = valid;
   assign bus0.CC_ADDER_ACC_last_In    = last;
   assign bus0.CC_ADDER_ACC_ready_In   = rdy_in;
   assign bus1.CC_ADDER_ACC_data_InBUS = data;
   assign bus1.CC_ADDER_ACC_valid_In   = valid;
   assign bus1.CC_ADDER_ACC_last_In    = last;
   assign bus1.CC_ADDER_ACC_ready_In   = rdy_in;
   assign bus2.CC_ADDER_ACC_data_InBUS = data;
   assign bus2.CC_ADDER_ACC_valid_In   = valid;
   assign bus2.CC_ADDER_ACC_last_In    = last;
   assign bus2.CC_ADDER_ACC_ready_In   = rdy_in;

   cc_adder_accumulator #(.NUMBER_DATAWIDTH(W), .NUMBER_INPUTS(N),
                          .SIGNED_MODE(0), .SATURATE_MODE(1)) dut0 (
      .CC_ADDER_ACC_CLOCK_50   (clk),
      .CC_ADDER_ACC_RESET_InLow(rst_n),
      .CC_ADDER_ACC_bus        (bus0)
   );
   cc_adder_accumulator #(.NUMBER_DATAWIDTH(W), .NUMBER_INPUTS(N),
                          .SIGNED_MODE(0), .SATURATE_MODE(0)) dut1 (
      .CC_ADDER_ACC_CLOCK_50   (clk),
      .CC_ADDER_ACC_RESET_InLow(rst_n),
      .CC_ADDER_ACC_bus        (bus1)
   );
   cc_adder_accumulator #(.NUMBER_DATAWIDTH(W), .NUMBER_INPUTS(N),
                          .SIGNED_MODE(1), .SATURATE_MODE(1)) dut2 (
      .CC_ADDER_ACC_CLOCK_50   (clk),
      .CC_ADDER_ACC_RESET_InLow(rst_n),
      .CC_ADDER_ACC_bus        (bus2)
   );

   logic [W-1:0]     sum_o   [3];
   logic             ovf_o   [3];
   logic [CNT_W-1:0] cnt_o   [3];
   logic             vld_o   [3];
   logic             rdy_o   [3];

   assign sum_o[0] = bus0.CC_ADDER_ACC_sum_OutBUS;
   assign sum_o[1] = bus1.CC_ADDER_ACC_sum_OutBUS;
   assign sum_o[2] = bus2.CC_ADDER_ACC_sum_OutBUS;
   assign ovf_o[0] = bus0.CC_ADDER_ACC_overflow_Out;
   assign ovf_o[1] = bus1.CC_ADDER_ACC_overflow_Out;
   assign ovf_o[2] = bus2.CC_ADDER_ACC_overflow_Out;
   assign cnt_o[0] = bus0.CC_ADDER_ACC_count_OutBUS;
   assign cnt_o[1] = bus1.CC_ADDER_ACC_count_OutBUS;
   assign cnt_o[2] = bus2.CC_ADDER_ACC_count_OutBUS;
   assign vld_o[0] = bus0.CC_ADDER_ACC_valid_Out;
   assign vld_o[1] = bus1.CC_ADDER_ACC_valid_Out;
   assign vld_o[2] = bus2.CC_ADDER_ACC_valid_Out;
   assign rdy_o[0] = bus0.CC_ADDER_ACC_ready_Out;
   assign rdy_o[1] = bus1.CC_ADDER_ACC_ready_Out;
   assign rdy_o[2] = bus2.CC_ADDER_ACC_ready_Out;

   typedef struct {
      logic [W-1:0] op [4];
      int           n;      // terms; last_In raised on term n-1
      int           gap;    // valid_In low cycles before term 2
      int           hold;   // ready_In low cycles while in DONE
      logic [W-1:0] s  [3]; // expected sum per dut
      logic         o  [3]; // expected overflow per dut
      int           cnt;
   } vec_t;

   task automatic check(input string name, input int d, input int got, input int exp);
      ncmp++;
      if (got != exp) begin
         nerr++;
         $display("FAIL %s dut%0d: got %0d (0x%0h) expected %0d (0x%0h)", name, d, got, got, exp, exp);
      end
   endtask

   task automatic check_result(input string tag, input vec_t v, input logic vld_exp, input logic rdy_exp);
      for (int d = 0; d < 3; d++) begin
         check({tag, " sum"},   d, int'(sum_o[d]), int'(v.s[d]));
         check({tag, " ovf"},   d, int'(ovf_o[d]), int'(v.o[d]));
         check({tag, " count"}, d, int'(cnt_o[d]), v.cnt);
         check({tag, " valid"}, d, int'(vld_o[d]), int'(vld_exp));
         check({tag, " ready"}, d, int'(rdy_o[d]), int'(rdy_exp));
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled there too.
   task automatic run_vector(input vec_t v);
      rdy_in = (v.hold == 0);
      for (int i = 0; i < v.n; i++) begin
         if (i == 2) begin
            for (int g = 0; g < v.gap; g++) begin
               valid = 1'b0;
               last  = 1'b0;
               @(negedge clk);
               check("stall ready", 0, int'(rdy_o[0]), 1);
               check("stall valid_out", 2, int'(vld_o[2]), 0);
            end
         end
         valid = 1'b1;
         data  = v.op[i];
         last  = (i == v.n - 1);
         check("accept ready", 0, int'(rdy_o[0]), 1);
         @(negedge clk);
      end
      valid = 1'b0;
      last  = 1'b0;
      data  = 8'hA5;
      check_result("result", v, 1'b1, 1'b0);
      for (int k = 0; k < v.hold; k++) begin
         @(negedge clk);
         check_result("held", v, 1'b1, 1'b0);
      end
      rdy_in = 1'b1;
      @(negedge clk);
      check_result("released", v, 1'b0, 1'b1);
   endtask

   function automatic vec_t mk(input logic [W-1:0] a, b, c, d, input int n, gap, hold,
                               input logic [W-1:0] su, input logic ou,
                               input logic [W-1:0] sw, input logic ow,
                               input logic [W-1:0] ss, input logic os, input int cnt);
      vec_t v;
      v.op[0] = a; v.op[1] = b; v.op[2] = c; v.op[3] = d;
      v.n = n; v.gap = gap; v.hold = hold;
      v.s[0] = su; v.o[0] = ou;
      v.s[1] = sw; v.o[1] = ow;
      v.s[2] = ss; v.o[2] = os;
      v.cnt = cnt;
      return v;
   endfunction

   vec_t vecs [9];
   vec_t v_after_reset;

   initial begin
      //              ops                          n gap hold  u-sat      u-wrap     s-sat      cnt
      vecs[0] = mk(8'd10, 8'd20, 8'd30, 8'd40,    4, 0, 0,  8'd100,0, 8'd100,0, 8'd100,0,   4);
      vecs[1] = mk(8'd200,8'd100,8'd0,  8'd0,     4, 3, 0,  8'd255,1, 8'd44, 1, 8'd44, 0,   4);
      vecs[2] = mk(8'h9C, 8'h9C, 8'd50, 8'd0,     4, 0, 5,  8'd255,1, 8'd106,1, 8'h80, 1,   4);
      vecs[3] = mk(8'd100,8'hE2, 8'hFB, 8'd7,     4, 0, 0,  8'd255,1, 8'd72, 1, 8'd72, 0,   4);
      vecs[4] = mk(8'd5,  8'd7,  8'd0,  8'd0,     2, 0, 0,  8'd12, 0, 8'd12, 0, 8'd12, 0,   2);
      vecs[5] = mk(8'd1,  8'd1,  8'd1,  8'd1,     4, 0, 0,  8'd4,  0, 8'd4,  0, 8'd4,  0,   4);
      vecs[6] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF,    4, 0, 0,  8'd255,1, 8'hFC, 1, 8'hFC, 0,   4);
      vecs[7] = mk(8'd127,8'd1,  8'd0,  8'd0,     2, 0, 0,  8'd128,0, 8'd128,0, 8'h7F, 1,   2);
      vecs[8] = mk(8'h42, 8'd0,  8'd0,  8'd0,     1, 0, 0,  8'h42, 0, 8'h42, 0, 8'h42, 0,   1);
      v_after_reset = mk(8'd1, 8'd2, 8'd3, 8'd4, 4, 0, 0, 8'd10,0, 8'd10,0, 8'd10,0, 4);

      rst_n  = 1'b0;
      data   = '0;
      valid  = 1'b0;
      last   = 1'b0;
      rdy_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int d = 0; d < 3; d++) begin
         check("reset sum",   d, int'(sum_o[d]), 0);
         check("reset ovf",   d, int'(ovf_o[d]), 0);
         check("reset count", d, int'(cnt_o[d]), 0);
         check("reset valid", d, int'(vld_o[d]), 0);
         check("reset ready", d, int'(rdy_o[d]), 1);
      end

      for (int i = 0; i < 9; i++) begin
         run_vector(vecs[i]);
      end

      // last_In without valid_In must not close a sum.
      valid = 1'b0;
      last  = 1'b1;
      @(negedge clk);
      check("stray last valid_out", 0, int'(vld_o[0]), 0);
      check("stray last ready", 0, int'(rdy_o[0]), 1);
      last = 1'b0;
      run_vector(vecs[0]);

      // Reset after two of four terms discards the partial sum.
      valid = 1'b1; last = 1'b0; data = 8'd50;
      @(negedge clk);
      data = 8'd60;
      @(negedge clk);
      valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int d = 0; d < 3; d++) begin
         check("midreset sum",   d, int'(sum_o[d]), 0);
         check("midreset ovf",   d, int'(ovf_o[d]), 0);
         check("midreset count", d, int'(cnt_o[d]), 0);
         check("midreset valid", d, int'(vld_o[d]), 0);
         check("midreset ready", d, int'(rdy_o[d]), 1);
      end
      run_vector(v_after_reset);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
